// File: rtl/hwt_golden_monitor.sv
// Field-side checker for the non_hwt path: recomputes Y = D & ((A & B) | C) on each
// sample, counts disagreements and escalates a dense run of them to a sticky alarm.
//
// state     | meaning
// S_MONITOR | no open episode, ep/clean counters at zero
// S_SUSPECT | episode open, counting mismatches and the clean run that ends it
// S_ALARM   | mismatch density reached THRESH; only clear or reset leaves
module hwt_golden_monitor #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 4,
  parameter int DECAY  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             y_obs,
  input  logic             clear,
  output logic             chk_valid,
  output logic             mismatch,
  output logic             suspect,
  output logic             alarm,
  output logic [CNT_W-1:0] err_total
);

  typedef enum logic [1:0] {S_MONITOR, S_SUSPECT, S_ALARM} state_t;

  state_t           state_q, state_d;
  logic [3:0]       ep_q, ep_d;
  logic [7:0]       clean_q, clean_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             chk_q, chk_d;
  logic             mm_q, mm_d;
  logic             suspect_q, suspect_d;
  logic             alarm_q, alarm_d;
  logic [1:0]       rel_q, rel_d;
  logic             run_en;
  logic             mm_now;

  // Release stages fill one per edge; the first filled stage opens the sample gate
  // so the second edge after rst_n rises is the first one that takes a sample.
  assign run_en = |rel_q;
  assign mm_now = (d & ((a & b) | c)) != y_obs;

  always_comb begin
    rel_d   = {rel_q[0], 1'b1};
    state_d = state_q;
    ep_d    = ep_q;
    clean_d = clean_q;
    err_d   = err_q;
    mm_d    = mm_q;
    chk_d   = 1'b0;
    if (clear) begin
      state_d = S_MONITOR;
      ep_d    = '0;
      clean_d = '0;
      err_d   = '0;
      mm_d    = 1'b0;
    end else if (in_valid && run_en) begin
      chk_d = 1'b1;
      mm_d  = mm_now;
      if (mm_now && !(&err_q)) err_d = err_q + 1'b1;
      case (state_q)
        S_MONITOR: begin
          if (mm_now) begin
            ep_d    = 4'd1;
            clean_d = '0;
            state_d = (THRESH == 1) ? S_ALARM : S_SUSPECT;
          end
        end
        S_SUSPECT: begin
          if (mm_now) begin
            ep_d    = (ep_q == 4'hF) ? ep_q : ep_q + 4'd1;
            clean_d = '0;
            if (ep_d >= 4'(THRESH)) state_d = S_ALARM;
          end else begin
            clean_d = clean_q + 8'd1;
            if (clean_d == 8'(DECAY)) begin
              state_d = S_MONITOR;
              ep_d    = '0;
              clean_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
    suspect_d = (state_d == S_SUSPECT);
    alarm_d   = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q     <= '0;
      state_q   <= S_MONITOR;
      ep_q      <= '0;
      clean_q   <= '0;
      err_q     <= '0;
      chk_q     <= 1'b0;
      mm_q      <= 1'b0;
      suspect_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      rel_q     <= rel_d;
      state_q   <= state_d;
      ep_q      <= ep_d;
      clean_q   <= clean_d;
      err_q     <= err_d;
      chk_q     <= chk_d;
      mm_q      <= mm_d;
      suspect_q <= suspect_d;
      alarm_q   <= alarm_d;
    end
  end

  assign chk_valid = chk_q;
  assign mismatch  = mm_q;
  assign suspect   = suspect_q;
  assign alarm     = alarm_q;
  assign err_total = err_q;

endmodule

// File: tb/tb_hwt_golden_monitor.sv
// Scoreboarded bench for hwt_golden_monitor with a small behavioural model of the
// episode FSM; CNT_W is narrowed to 4 so counter saturation is reachable.
module tb_hwt_golden_monitor;
  localparam int CNT_W  = 4;
  localparam int THRESH = 4;
  localparam int DECAY  = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, y_obs = 1'b0, clear = 1'b0;
  logic chk_valid, mismatch, suspect, alarm;
  logic [CNT_W-1:0] err_total;

  hwt_golden_monitor #(.CNT_W(CNT_W), .THRESH(THRESH), .DECAY(DECAY)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c), .d(d),
    .y_obs(y_obs), .clear(clear), .chk_valid(chk_valid), .mismatch(mismatch),
    .suspect(suspect), .alarm(alarm), .err_total(err_total)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic             mm;
    logic [CNT_W-1:0] err;
  } exp_t;
  exp_t exp_q[$];

  // model: state 0=MONITOR 1=SUSPECT 2=ALARM
  int   m_state = 0, m_ep = 0, m_clean = 0, m_err = 0, m_rel = 0;
  logic m_mm = 1'b0;

  always @(negedge clk) begin
    if (rst_n && chk_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pulse got chk_valid=1 exp no pending sample");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({mismatch, err_total} !== {e.mm, e.err}) begin
          failures++;
          $display("FAIL sb_result got mm=%0b err=%0d exp mm=%0b err=%0d",
                   mismatch, err_total, e.mm, e.err);
        end
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] abcd, input logic y, input logic clr);
    logic ge, mm;
    exp_t e;
    in_valid = v; {a, b, c, d} = abcd; y_obs = y; clear = clr;
    ge = abcd[0] & ((abcd[3] & abcd[2]) | abcd[1]);
    mm = (ge != y);
    if (clr) begin
      m_state = 0; m_ep = 0; m_clean = 0; m_err = 0; m_mm = 1'b0;
    end else if (v && m_rel >= 1) begin
      m_mm = mm;
      if (mm && m_err < (1 << CNT_W) - 1) m_err++;
      case (m_state)
        0: if (mm) begin
             m_ep = 1; m_clean = 0; m_state = (THRESH == 1) ? 2 : 1;
           end
        1: if (mm) begin
             if (m_ep < 15) m_ep++;
             m_clean = 0;
             if (m_ep >= THRESH) m_state = 2;
           end else begin
             m_clean++;
             if (m_clean == DECAY) begin m_state = 0; m_ep = 0; m_clean = 0; end
           end
        default: ;
      endcase
      e.mm = mm; e.err = CNT_W'(m_err);
      exp_q.push_back(e);
    end
    if (m_rel < 2) m_rel++;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({chk_valid, mismatch, suspect, alarm, err_total} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %b exp all zero", {chk_valid, mismatch, suspect, alarm, err_total});
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (suspect !== 1'b0 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got suspect=%0b alarm=%0b exp 0 0", suspect, alarm);
    end
  endtask

  task automatic test_golden();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step(1'b1, v, v[0] & ((v[3] & v[2]) | v[1]), 1'b0);
    end
    checks++;
    if (err_total !== '0 || suspect !== 1'b0 || alarm !== 1'b0 || mismatch !== 1'b0) begin
      failures++;
      $display("FAIL golden_final got err=%0d sus=%0b alm=%0b mm=%0b exp 0 0 0 0",
               err_total, suspect, alarm, mismatch);
    end
  endtask

  task automatic test_trojan();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'hF, 1'b0, 1'b0);
    checks++;
    if (suspect !== 1'b1 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL trojan_first got sus=%0b alm=%0b exp 1 0", suspect, alarm);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'hF, 1'b1, 1'b0);
      step(1'b1, 4'hF, 1'b0, 1'b0);
    end
    step(1'b1, 4'hF, 1'b1, 1'b0);
    checks++;
    if (alarm !== 1'b0 || err_total !== 4'd3) begin
      failures++;
      $display("FAIL trojan_third got alm=%0b err=%0d exp 0 3", alarm, err_total);
    end
    step(1'b1, 4'hF, 1'b0, 1'b0);
    checks++;
    if (alarm !== 1'b1 || err_total !== 4'd4 || suspect !== 1'b0) begin
      failures++;
      $display("FAIL trojan_alarm got alm=%0b err=%0d sus=%0b exp 1 4 0", alarm, err_total, suspect);
    end
    step(1'b1, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'hF, 1'b1, 1'b0);
    checks++;
    if (alarm !== 1'b1 || err_total !== 4'd5 || chk_valid !== 1'b0 || mismatch !== 1'b1) begin
      failures++;
      $display("FAIL trojan_sticky got alm=%0b err=%0d chk=%0b mm=%0b exp 1 5 0 1",
               alarm, err_total, chk_valid, mismatch);
    end
  endtask

  task automatic test_decay();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1011, 1'b0, 1'b0);
    for (int k = 0; k < DECAY - 1; k++) step(1'b1, 4'b1011, 1'b1, 1'b0);
    checks++;
    if (suspect !== 1'b1) begin
      failures++;
      $display("FAIL decay_hold got sus=%0b exp 1", suspect);
    end
    step(1'b1, 4'b1011, 1'b1, 1'b0);
    checks++;
    if (suspect !== 1'b0 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL decay_exit got sus=%0b alm=%0b exp 0 0", suspect, alarm);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 1'b1, 1'b0);
    checks++;
    if (suspect !== 1'b1 || alarm !== 1'b0 || err_total !== 4'd6) begin
      failures++;
      $display("FAIL decay_new_episode got sus=%0b alm=%0b err=%0d exp 1 0 6", suspect, alarm, err_total);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step(1'b1, v, ~(v[0] & ((v[3] & v[2]) | v[1])), 1'b0);
    end
    checks++;
    if (err_total !== 4'd15 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL saturation got err=%0d alm=%0b exp 15 1", err_total, alarm);
    end
  endtask

  task automatic test_clear_collision();
    step(1'b1, 4'hF, 1'b0, 1'b1);
    checks++;
    if ({alarm, suspect, chk_valid, mismatch, err_total} !== '0) begin
      failures++;
      $display("FAIL clear_collision got alm=%0b sus=%0b chk=%0b mm=%0b err=%0d exp all 0",
               alarm, suspect, chk_valid, mismatch, err_total);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 4'hF, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0, 1'b0);
    checks++;
    if (suspect !== 1'b1 || err_total !== 4'd2) begin
      failures++;
      $display("FAIL async_pre got sus=%0b err=%0d exp 1 2", suspect, err_total);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({chk_valid, mismatch, suspect, alarm, err_total} !== '0) begin
      failures++;
      $display("FAIL async_immediate got %b exp all zero", {chk_valid, mismatch, suspect, alarm, err_total});
    end
    m_state = 0; m_ep = 0; m_clean = 0; m_err = 0; m_mm = 1'b0; m_rel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'hF, 1'b0, 1'b0);
    checks++;
    if (chk_valid !== 1'b0 || err_total !== 4'd0) begin
      failures++;
      $display("FAIL async_first_edge got chk=%0b err=%0d exp 0 0", chk_valid, err_total);
    end
    step(1'b1, 4'hF, 1'b0, 1'b0);
    checks++;
    if (chk_valid !== 1'b1 || err_total !== 4'd1 || suspect !== 1'b1) begin
      failures++;
      $display("FAIL async_second_edge got chk=%0b err=%0d sus=%0b exp 1 1 1", chk_valid, err_total, suspect);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rel = 0;
    test_reset();
    test_golden();
    test_trojan();
    test_decay();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    step(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got pending=%0d exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hwt_golden_monitor.md
# hwt_golden_monitor

Runtime checker on the observing side of the `non_hwt` 4-input function path. It samples the function's inputs A–D together with the produced output Y. It recomputes the golden value Y = D & ((A & B) | C) and flags mismatches. A mismatch-density state machine escalates to a sticky alarm, which lets the design detect a trojan-modified implementation in the field.

## Interface
Parameters:
- `CNT_W`, 8: width of the total-error counter `err_total`.
- `THRESH`, 4: mismatches in the current suspicion episode that raise the alarm. Range is 1..15.
- `DECAY`, 8: consecutive clean samples in SUSPECT that return the block to MONITOR. Range is 1..255.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: the current A, B, C, D and y_obs form one sample.
- `a`, `b`, `c`, `d`, in, 1 each: function inputs as driven to the monitored logic.
- `y_obs`, in, 1: Y as produced by the monitored logic.
- `clear`, in, 1: synchronous clear of the state and all counters.
- `chk_valid`, out, 1: one-cycle pulse. A comparison result is present.
- `mismatch`, out, 1: the result of the last comparison. Valid when `chk_valid` is high.
- `suspect`, out, 1: high while in SUSPECT.
- `alarm`, out, 1: high while in ALARM. Sticky.
- `err_total`, out, CNT_W: saturating count of all mismatches since reset or clear.

## Operation
- Golden function: `y_exp = d & ((a & b) | c)`. A mismatch is `y_exp != y_obs`, computed combinationally and registered on the sampling edge.
- Edge with `in_valid`=1 and `clear`=0:
  - `chk_valid` becomes 1 and `mismatch` is loaded.
  - On a mismatch, `err_total` increments and saturates at 2^CNT_W−1.
- Edge with `in_valid`=0: `chk_valid` becomes 0. `mismatch` holds its value.
- Internal counters:
  - `ep_cnt` is 4 bits. It counts mismatches in the current episode and saturates at 15.
  - `clean_cnt` is 8 bits. It counts consecutive clean samples.
- States and transitions:
  - MONITOR: `ep_cnt`=0 and `clean_cnt`=0.
    - A mismatch sets `ep_cnt`=1. If THRESH=1 the block goes to ALARM, otherwise to SUSPECT.
  - SUSPECT:
    - A mismatch increments `ep_cnt` and sets `clean_cnt`=0. If `ep_cnt` becomes ≥THRESH the block goes to ALARM.
    - A clean sample increments `clean_cnt`. When `clean_cnt` reaches DECAY, the block returns to MONITOR and `ep_cnt` and `clean_cnt` go to 0.
  - ALARM: absorbing. Only `clear` or reset leaves it. `err_total` keeps counting in ALARM.
- `clear`=1 on an edge:
  - State goes to MONITOR.
  - `ep_cnt`, `clean_cnt`, `err_total`, `chk_valid` and `mismatch` go to 0.
  - A sample presented in the same cycle is discarded. Clear wins over `in_valid`.
- Samples with `in_valid`=0 do not affect any counter or state.

## Timing
- Reset values: `chk_valid`=0, `mismatch`=0, `suspect`=0, `alarm`=0, `err_total`=0, state MONITOR.
- Reset is asynchronous assert and is released synchronously internally through a 2-flop release synchronizer. The block accepts its first sample on the second rising edge after `rst_n` rises.
- Latency: a sample taken at edge N produces `chk_valid`, `mismatch` and `err_total` at edge N, visible during cycle N+1.
- `suspect` and `alarm` are registered state decodes and update on the same edge N.
- The alarm asserts in the cycle after the THRESH-th mismatch in an episode.
- Back-to-back samples are accepted every cycle. No backpressure.
- Reset asserted mid-episode immediately forces all outputs to their reset values.

## Test plan
- Exhaustive golden pass: all 16 {a,b,c,d} with a correct y_obs, `in_valid` every cycle. Expect 16 `chk_valid` pulses, `mismatch`=0 throughout, `err_total`=0, state MONITOR.
- Trojan injection: with {a,b,c,d}=1111, drive y_obs=0 four times with clean samples interleaved. Expect `suspect`=1 after the first mismatch and `alarm`=1 the cycle after the fourth mismatch, with `err_total`=4. Further mismatches raise `err_total` to 5 and `alarm` stays 1.
- Decay: 3 mismatches, then 8 consecutive clean samples. Expect `suspect` to drop after the 8th clean sample and `alarm` to stay 0. A following single mismatch starts a new episode with `ep_cnt`=1, so `alarm` stays 0.
- Saturation: with CNT_W=4, 20 mismatches. Expect `err_total` to hold at 15 and `alarm`=1.
- Clear collision: in ALARM, assert `clear` together with an `in_valid` mismatch sample. Expect `alarm`=0, `err_total`=0, `chk_valid`=0 on the next cycle, and the sample not counted.
- Async reset mid-SUSPECT: drop `rst_n` between edges. Expect outputs to go to 0 immediately, and the first sample after release to be accepted on the second edge.
